// File: rtl/scaler_cfg_if.sv
// scaler_cfg_if: valid/ready configuration bundle offered to scaler_cfg_ctrl
interface scaler_cfg_if #(
  parameter int INPUT_X_RES_WIDTH  = 11,
  parameter int INPUT_Y_RES_WIDTH  = 11,
  parameter int OUTPUT_X_RES_WIDTH = 11,
  parameter int OUTPUT_Y_RES_WIDTH = 11
);
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [INPUT_X_RES_WIDTH-1:0]  cfg_start_x;
  logic [INPUT_X_RES_WIDTH-1:0]  cfg_end_x;
  logic [INPUT_Y_RES_WIDTH-1:0]  cfg_start_y;
  logic [INPUT_Y_RES_WIDTH-1:0]  cfg_end_y;
  logic [OUTPUT_X_RES_WIDTH-1:0] cfg_out_x_res;
  logic [OUTPUT_Y_RES_WIDTH-1:0] cfg_out_y_res;
  logic                          cfg_algorithm;
  modport master (
    output cfg_valid, cfg_start_x, cfg_end_x, cfg_start_y, cfg_end_y,
           cfg_out_x_res, cfg_out_y_res, cfg_algorithm,
    input  cfg_ready
  );
  modport slave (
    input  cfg_valid, cfg_start_x, cfg_end_x, cfg_start_y, cfg_end_y,
           cfg_out_x_res, cfg_out_y_res, cfg_algorithm,
    output cfg_ready
  );
endinterface

// File: rtl/scaler_cfg_ctrl.sv
// scaler_cfg_ctrl: frame-synchronous crop/scale configuration with shared sequential divider
module scaler_cfg_ctrl #(
  parameter int INPUT_X_RES_WIDTH  = 11,
  parameter int INPUT_Y_RES_WIDTH  = 11,
  parameter int OUTPUT_X_RES_WIDTH = 11,
  parameter int OUTPUT_Y_RES_WIDTH = 11,
  parameter int SCALE_INT_BITS     = 4,
  parameter int SCALE_FRAC_BITS    = 14,
  parameter int SCALE_BITS         = SCALE_INT_BITS + SCALE_FRAC_BITS,
  parameter int H_DISP             = 1920,
  parameter int V_DISP             = 1080
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vs_i,
  scaler_cfg_if.slave                   cfg,
  output logic [INPUT_X_RES_WIDTH-1:0]  START_X,
  output logic [INPUT_X_RES_WIDTH-1:0]  END_X,
  output logic [INPUT_Y_RES_WIDTH-1:0]  START_Y,
  output logic [INPUT_Y_RES_WIDTH-1:0]  END_Y,
  output logic [INPUT_X_RES_WIDTH-1:0]  inputXRes,
  output logic [INPUT_Y_RES_WIDTH-1:0]  inputYRes,
  output logic [OUTPUT_X_RES_WIDTH-1:0] outputXRes,
  output logic [OUTPUT_Y_RES_WIDTH-1:0] outputYRes,
  output logic [SCALE_BITS-1:0]         xScale,
  output logic [SCALE_BITS-1:0]         yScale,
  output logic                          Algorithm,
  output logic                          cfg_applied,
  output logic                          cfg_err
);
  localparam int XW = INPUT_X_RES_WIDTH;
  localparam int YW = INPUT_Y_RES_WIDTH;
  localparam int OXW = OUTPUT_X_RES_WIDTH;
  localparam int OYW = OUTPUT_Y_RES_WIDTH;
  localparam int IW = (XW > YW) ? XW : YW;
  localparam int OW = (OXW > OYW) ? OXW : OYW;
  // wide enough for dividend << FRAC and divisor << (SCALE_BITS-1) without truncation
  localparam int DW = IW + OW + SCALE_BITS + 2;
  localparam int CW = $clog2(SCALE_BITS);
  localparam logic [SCALE_BITS-1:0] UNITY = SCALE_BITS'(1) << SCALE_FRAC_BITS;

  typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, PEND} state_t;
  state_t state_q, state_d;

  logic [XW-1:0]         sh_sx_q, sh_ex_q, sh_ix_q;
  logic [YW-1:0]         sh_sy_q, sh_ey_q, sh_iy_q;
  logic [OXW-1:0]        sh_ox_q;
  logic [OYW-1:0]        sh_oy_q;
  logic                  sh_alg_q;
  logic [SCALE_BITS-1:0] sh_xs_q, sh_ys_q;
  logic                  err_q, applied_q, vs_q;
  logic [DW-1:0]         rem_q, dvs_q;
  logic [SCALE_BITS-1:0] quo_q;
  logic [CW-1:0]         cnt_q;
  logic                  ovf_q;

  logic                  ready, accept, apply, bad, vs_rise, div_last, ld_x, ld_y, ld_ovf, ge;
  logic [XW-1:0]         x_span;
  logic [YW-1:0]         y_span;
  logic [DW-1:0]         ld_n, ld_d, rem_nx;
  logic [SCALE_BITS-1:0] quo_nx, div_res;

  assign accept   = cfg.cfg_valid & ready;
  assign vs_rise  = vs_i & ~vs_q;
  assign x_span   = sh_ex_q - sh_sx_q;
  assign y_span   = sh_ey_q - sh_sy_q;
  assign bad      = (sh_ex_q <= sh_sx_q) | (sh_ey_q <= sh_sy_q);
  assign div_last = cnt_q == '0;
  assign ld_x     = (state_q == CHECK) & ~bad;
  assign ld_y     = (state_q == DIV_X) & div_last;
  assign ld_n     = ld_x ? DW'(x_span) : DW'(y_span);
  assign ld_d     = ld_x ? DW'(sh_ox_q) + DW'(1) : DW'(sh_oy_q) + DW'(1);
  // a quotient needing more than SCALE_INT_BITS integer bits saturates instead of dividing
  assign ld_ovf   = ld_n >= (ld_d << SCALE_INT_BITS);
  assign ge       = rem_q >= dvs_q;
  assign rem_nx   = ge ? rem_q - dvs_q : rem_q;
  assign quo_nx   = {quo_q[SCALE_BITS-2:0], ge};
  assign div_res  = ovf_q ? '1 : quo_nx;

  assign cfg.cfg_ready = ready;
  assign cfg_applied   = applied_q;
  assign cfg_err       = err_q;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  // next state, ready and apply strobe; an accept in PEND beats a same-cycle frame edge
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    apply   = 1'b0;
    case (state_q)
      IDLE: begin
        ready   = 1'b1;
        state_d = accept ? CHECK : IDLE;
      end
      CHECK: state_d = bad ? IDLE : DIV_X;
      DIV_X: state_d = div_last ? DIV_Y : DIV_X;
      DIV_Y: state_d = div_last ? PEND : DIV_Y;
      PEND: begin
        ready   = 1'b1;
        apply   = ~accept & vs_rise;
        state_d = accept ? CHECK : (vs_rise ? IDLE : PEND);
      end
      default: state_d = IDLE;
    endcase
  end

  // previous frame sync for rising-edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vs_q <= 1'b0;
    else        vs_q <= vs_i;

  // restoring divider: one quotient bit per cycle, MSB first, divisor walks right
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (ld_x | ld_y) begin
      rem_q <= ld_n << SCALE_FRAC_BITS;
      dvs_q <= ld_d << (SCALE_BITS - 1);
      quo_q <= '0;
      cnt_q <= CW'(SCALE_BITS - 1);
      ovf_q <= ld_ovf;
    end else if (state_q == DIV_X || state_q == DIV_Y) begin
      rem_q <= rem_nx;
      dvs_q <= dvs_q >> 1;
      quo_q <= quo_nx;
      cnt_q <= cnt_q - CW'(1);
    end

  // shadow set, derived resolutions, scale results and sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh_sx_q  <= '0;
      sh_ex_q  <= '0;
      sh_sy_q  <= '0;
      sh_ey_q  <= '0;
      sh_ox_q  <= '0;
      sh_oy_q  <= '0;
      sh_alg_q <= 1'b0;
      sh_ix_q  <= '0;
      sh_iy_q  <= '0;
      sh_xs_q  <= '0;
      sh_ys_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      sh_sx_q  <= cfg.cfg_start_x;
      sh_ex_q  <= cfg.cfg_end_x;
      sh_sy_q  <= cfg.cfg_start_y;
      sh_ey_q  <= cfg.cfg_end_y;
      sh_ox_q  <= cfg.cfg_out_x_res;
      sh_oy_q  <= cfg.cfg_out_y_res;
      sh_alg_q <= cfg.cfg_algorithm;
      err_q    <= 1'b0;
    end else begin
      sh_ix_q <= (state_q == CHECK) ? x_span - XW'(1) : sh_ix_q;
      sh_iy_q <= (state_q == CHECK) ? y_span - YW'(1) : sh_iy_q;
      sh_xs_q <= (state_q == DIV_X && div_last) ? div_res : sh_xs_q;
      sh_ys_q <= (state_q == DIV_Y && div_last) ? div_res : sh_ys_q;
      err_q   <= err_q | ((state_q == CHECK) & bad) | ((ld_x | ld_y) & ld_ovf);
    end

  // active set loads atomically from the shadow on the applying frame edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      START_X    <= '0;
      END_X      <= XW'(H_DISP);
      START_Y    <= '0;
      END_Y      <= YW'(V_DISP);
      inputXRes  <= XW'(H_DISP - 1);
      inputYRes  <= YW'(V_DISP - 1);
      outputXRes <= OXW'(H_DISP - 1);
      outputYRes <= OYW'(V_DISP - 1);
      xScale     <= UNITY;
      yScale     <= UNITY;
      Algorithm  <= 1'b0;
      applied_q  <= 1'b0;
    end else begin
      applied_q <= apply;
      if (apply) begin
        START_X    <= sh_sx_q;
        END_X      <= sh_ex_q;
        START_Y    <= sh_sy_q;
        END_Y      <= sh_ey_q;
        inputXRes  <= sh_ix_q;
        inputYRes  <= sh_iy_q;
        outputXRes <= sh_ox_q;
        outputYRes <= sh_oy_q;
        xScale     <= sh_xs_q;
        yScale     <= sh_ys_q;
        Algorithm  <= sh_alg_q;
      end
    end
endmodule

// File: doc/scaler_cfg_ctrl.md
Name: scaler_cfg_ctrl

Overview:
- Frame-synchronous configuration controller for the crop/scale datapath (image_cut, streamScaler).
- Accepts a new crop window, output resolution and algorithm select over a valid/ready handshake.
- Derives inputXRes/inputYRes and computes xScale/yScale with a shared sequential restoring divider, replacing the combinational divides.
- Applies all values atomically on the next vs_i rising edge, so the datapath never sees a mixed configuration within a frame.

Parameters:
- INPUT_X_RES_WIDTH, 11, crop X coordinate / input resolution width
- INPUT_Y_RES_WIDTH, 11, crop Y coordinate / input resolution width
- OUTPUT_X_RES_WIDTH, 11, output X resolution width
- OUTPUT_Y_RES_WIDTH, 11, output Y resolution width
- SCALE_INT_BITS, 4, integer bits of the scale factor
- SCALE_FRAC_BITS, 14, fractional bits of the scale factor
- SCALE_BITS, SCALE_INT_BITS+SCALE_FRAC_BITS, scale factor width (Q4.14)
- H_DISP, 1920, reset crop END_X and reset output width
- V_DISP, 1080, reset crop END_Y and reset output height

Ports:
- clk  in  1  single clock (scaler clock domain)
- rst_n  in  1  asynchronous active-low reset
- vs_i  in  1  frame sync, active high, synchronous to clk
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  controller can accept a configuration
- cfg_start_x / cfg_end_x  in  INPUT_X_RES_WIDTH  requested crop X window
- cfg_start_y / cfg_end_y  in  INPUT_Y_RES_WIDTH  requested crop Y window
- cfg_out_x_res / cfg_out_y_res  in  OUTPUT_*_RES_WIDTH  requested output resolution minus 1
- cfg_algorithm  in  1  1 = nearest neighbour, 0 = bilinear
- START_X, END_X, START_Y, END_Y  out  as inputs  active crop window
- inputXRes, inputYRes  out  INPUT_*_RES_WIDTH  active input resolution minus 1
- outputXRes, outputYRes  out  OUTPUT_*_RES_WIDTH  active output resolution minus 1
- xScale, yScale  out  SCALE_BITS  active Q4.14 scale factors
- Algorithm  out  1  active algorithm select
- cfg_applied  out  1  one-cycle pulse when the active set updates
- cfg_err  out  1  sticky error; cleared on the next accepted configuration

Behaviour:
- Reset values:
  - START_X = START_Y = 0, END_X = H_DISP, END_Y = V_DISP
  - inputXRes = outputXRes = H_DISP-1, inputYRes = outputYRes = V_DISP-1
  - xScale = yScale = 0x4000
  - Algorithm = 0, cfg_applied = 0, cfg_err = 0
  - cfg_ready = 1, state IDLE
- Handshake:
  - A transfer occurs when cfg_valid & cfg_ready at a rising clk edge; inputs are captured into shadow registers.
  - cfg_ready = 1 in IDLE and PEND, 0 otherwise.
- State machine:
  - IDLE --accept--> CHECK
  - CHECK (1 cycle):
    - If end_x <= start_x or end_y <= start_y: set cfg_err and return to IDLE. Active set is unchanged and nothing is applied.
    - Otherwise compute in_x = end_x-start_x-1 and in_y = end_y-start_y-1 (module width) and go to DIV_X.
  - DIV_X (18 cycles): xq = floor(((in_x+1)<<14)/(out_x+1)).
    - Overflow pre-check: if (in_x+1) >= 16*(out_x+1), skip the division, force xq = 2^SCALE_BITS-1 and set cfg_err. The result is still applied.
    - All intermediate arithmetic is at least INPUT_X_RES_WIDTH+SCALE_FRAC_BITS+1 bits with no truncation.
  - DIV_Y (18 cycles): same rule for the Y axis, reusing the same divider --> PEND.
  - PEND: wait for a vs_i rising edge, detected from a registered previous value.
  - PEND + vs_i rising edge: all active outputs load from shadow on that edge, cfg_applied = 1 for exactly that cycle --> IDLE.
- Latency:
  - Accept to PEND is at most 38 cycles.
  - Apply happens on the first vs_i rising edge at or after PEND entry; the outputs change in the cycle following the detected edge.
- Boundary cases:
  - vs_i edge during CHECK/DIV_X/DIV_Y: ignored; the configuration waits for the following frame.
  - New accept while in PEND: the pending set is discarded, cfg_err is cleared, and the controller restarts at CHECK. The new set is applied no earlier than its own completion.
  - Accept in PEND and vs_i edge in the same cycle: the accept wins and nothing is applied.
  - Reset mid-operation: asynchronously returns every output and the state to reset values; the pending configuration is lost.
  - cfg_valid held high while cfg_ready = 0: no capture, no side effects.

Test Plan:
- Reset release with no configuration -> xScale = yScale = 0x4000, inputXRes = 1919, inputYRes = 1079, cfg_ready = 1, cfg_applied never pulses.
- Accept start = (0,0), end = (1920,1080), out = (959,539), then vs_i edge -> after the edge inputXRes = 1919, xScale = yScale = 0x08000, Algorithm follows cfg_algorithm, one cfg_applied pulse, cfg_err = 0.
- Accept end = (640,480), out = (1919,1079) -> xScale = 0x01555, yScale = 0x01C71. These must not appear before the vs_i edge, even if the edge occurs 10 cycles after accept.
- Accept end_x = 1920, out_x = 99 -> xScale = 0x3FFFF, cfg_err = 1, yScale correct for its axis, applied on vs_i.
- Accept start_x = 100, end_x = 100 -> cfg_err = 1, returns to IDLE, no cfg_applied on the next three vs_i edges, active outputs unchanged.
- Accept config A, then while in PEND accept config B, then vs_i edge -> only B applied; assert rst_n = 0 mid-DIV_X -> all outputs at reset values immediately (asynchronously).
